// File: rtl/apb_rr_scheduler_pkg.sv
// Shared definitions for the APB round-robin scheduler: FSM encoding,
// the APB slave address map and the default access timeout.
package apb_rr_scheduler_pkg;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DERR   = 2'd3
  } state_t;

  // Slave address map: NSLAVE equally sized windows starting at SLAVE_BASE.
  localparam int          NSLAVE      = 3;
  localparam logic [31:0] SLAVE_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLAVE_SIZE  = 32'h0400_0000;
  localparam int          SLAVE_SHIFT = $clog2(SLAVE_SIZE);
  localparam int          REGION_W    = 32 - SLAVE_SHIFT;

  // Maximum number of ACCESS cycles spent waiting for pready.
  localparam int DEFAULT_TIMEOUT = 16;

  // Region number of an address (the bits above one slave window).
  function automatic logic [REGION_W-1:0] addr_region(input logic [31:0] addr);
    return addr[31:SLAVE_SHIFT];
  endfunction

endpackage

// File: rtl/apb_rr_scheduler_if.sv
// APB bus bundle between the scheduler (master) and the peripheral slaves.
interface apb_rr_scheduler_if;

  logic [apb_rr_scheduler_pkg::NSLAVE-1:0] psel;
  logic                                    penable;
  logic                                    pwrite;
  logic [31:0]                             paddr;
  logic [31:0]                             pwdata;
  logic [31:0]                             prdata;
  logic                                    pready;
  logic                                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_rr_scheduler_slave_decode.sv
// Combinational APB slave decoder: address -> one-hot slave select and hit.
// Shared with other bridge blocks, so it only depends on the package map.
module apb_slave_decode
  import apb_rr_scheduler_pkg::*;
(
  input  logic [31:0]       addr,
  output logic [NSLAVE-1:0] sel,
  output logic              hit
);

  logic [REGION_W-1:0] region;

  assign region = addr_region(addr);

  // One comparator per slave window; windows are contiguous from SLAVE_BASE.
  for (genvar gi = 0; gi < NSLAVE; gi++) begin : g_slave
    localparam logic [REGION_W-1:0] SLAVE_REGION =
      REGION_W'((SLAVE_BASE >> SLAVE_SHIFT) + gi);
    assign sel[gi] = (region == SLAVE_REGION);
  end

  assign hit = |sel;

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin scheduler sharing one APB master port among NREQ requesters.
// Latches the winner's transfer, runs SETUP/ACCESS with a pready timeout and
// returns a one-cycle done pulse with read data and error status.
module apb_rr_scheduler
  import apb_rr_scheduler_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [31:0]          rdata,
  output logic                 err,
  apb_rr_scheduler_if.master   apb
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        last_reg, last_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [NREQ-1:0]         gnt_reg, gnt_next;
  logic [NREQ-1:0]         done_reg, done_next;
  logic [31:0]             rdata_reg, rdata_next;
  logic                    err_reg, err_next;
  logic [NSLAVE-1:0]       psel_reg, psel_next;
  logic                    penable_reg, penable_next;
  logic                    pwrite_reg, pwrite_next;
  logic [31:0]             paddr_reg, paddr_next;
  logic [31:0]             pwdata_reg, pwdata_next;

  logic [31:0]             addr_arr [NREQ];
  logic [31:0]             wdata_arr [NREQ];
  logic [NREQ-1:0]         eligible;
  logic                    found;
  logic [IDX_W-1:0]        win;
  logic [31:0]             win_addr;
  logic [NSLAVE-1:0]       win_sel;
  logic                    win_hit;

  // Unpack the flattened per-requester address and write-data buses.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[32*gi +: 32];
    assign wdata_arr[gi] = req_wdata[32*gi +: 32];
  end

  // Round-robin search starting just after the last winner; a requester whose
  // done is visible this cycle is masked so it cannot be re-granted at once.
  always_comb begin
    eligible = req & ~done_reg;
    found    = 1'b0;
    win      = last_reg;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && eligible[(int'(last_reg) + i) % NREQ]) begin
        found = 1'b1;
        win   = IDX_W'((int'(last_reg) + i) % NREQ);
      end
    end
  end

  assign win_addr = addr_arr[win];

  apb_slave_decode u_decode (
    .addr (win_addr),
    .sel  (win_sel),
    .hit  (win_hit)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    done_next    = '0;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    pwrite_next  = pwrite_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          gnt_next      = '0;
          gnt_next[win] = 1'b1;
          last_next     = win;
          cnt_next      = '0;
          paddr_next    = win_addr;
          pwdata_next   = wdata_arr[win];
          pwrite_next   = req_write[win];
          penable_next  = 1'b0;
          if (win_hit) begin
            psel_next  = win_sel;
            state_next = ST_SETUP;
          end else begin
            psel_next  = '0;
            state_next = ST_DERR;
          end
        end
      end

      // SETUP lasts exactly one cycle; pready/pslverr are not looked at here.
      ST_SETUP: begin
        penable_next = 1'b1;
        state_next   = ST_ACCESS;
      end

      ST_ACCESS: begin
        cnt_next = cnt_reg + 1'b1;
        if (apb.pready) begin
          psel_next    = '0;
          penable_next = 1'b0;
          done_next    = gnt_reg;
          gnt_next     = '0;
          err_next     = apb.pslverr;
          if (!pwrite_reg) begin
            rdata_next = apb.prdata;
          end
          state_next   = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          // Slave never answered: abort with error, read data untouched.
          psel_next    = '0;
          penable_next = 1'b0;
          done_next    = gnt_reg;
          gnt_next     = '0;
          err_next     = 1'b1;
          state_next   = ST_IDLE;
        end
      end

      // Unmapped address: one quiet cycle, then complete with error.
      ST_DERR: begin
        done_next  = gnt_reg;
        gnt_next   = '0;
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset asserts immediately, releases on hclk.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg   <= ST_IDLE;
      last_reg    <= LAST_INIT;
      cnt_reg     <= '0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      psel_reg    <= '0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
    end
  end

  assign gnt         = gnt_reg;
  assign done        = done_reg;
  assign rdata       = rdata_reg;
  assign err         = err_reg;
  assign apb.psel    = psel_reg;
  assign apb.penable = penable_reg;
  assign apb.pwrite  = pwrite_reg;
  assign apb.paddr   = paddr_reg;
  assign apb.pwdata  = pwdata_reg;

endmodule
